// File: rtl/demux_stream.sv
// ---------------------------------------------------------------------------
// demux_stream
//   Registered 1-to-N stream demultiplexer. Each input word is routed to one
//   of N_OUT = 2**SEL_W output channels. Every channel has a one-entry
//   holding register and its own back-pressure.
//
//   Optional feature macro: DEMUX_RR_EN
//     defined   -> d_mode=1 selects round-robin routing driven by d_rr_ptr
//     undefined -> d_mode ignored, target is always d_sel, d_rr_ptr = 0
//
// Handshake: a word moves across an interface on a rising clk edge where
// both valid and ready are high. Valid never depends on ready. d_in_ready is
// combinational from the target channel state, d_sel, d_mode and
// d_out_ready. There is no combinational path from d_in to any output.
//
// Ports
//   clk, rst     : clock, synchronous active-high reset
//   d_in         : input word          d_in_valid / d_in_ready : input handshake
//   d_sel        : directed target     d_mode : 0 directed, 1 round-robin
//   d_out        : channel k at [k*WIDTH +: WIDTH]
//   d_out_valid  : per-channel valid   d_out_ready : per-channel consumer ready
//   d_rr_ptr     : current round-robin target
// ---------------------------------------------------------------------------
module demux_stream #(
  parameter int WIDTH = 8,
  parameter int SEL_W = 2,
  localparam int N_OUT = 2 ** SEL_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       d_in,
  input  logic                   d_in_valid,
  output logic                   d_in_ready,
  input  logic [SEL_W-1:0]       d_sel,
  input  logic                   d_mode,
  output logic [N_OUT*WIDTH-1:0] d_out,
  output logic [N_OUT-1:0]       d_out_valid,
  input  logic [N_OUT-1:0]       d_out_ready,
  output logic [SEL_W-1:0]       d_rr_ptr
);

  logic [N_OUT-1:0][WIDTH-1:0] data_q, data_d;
  logic [N_OUT-1:0]            valid_q, valid_d;
  logic [SEL_W-1:0]            target;
  logic                        accept;

`ifdef DEMUX_RR_EN
  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;

  // Pointer advances only on words actually accepted in round-robin mode,
  // so a full, stalled target blocks the input rather than being skipped.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept && d_mode) begin
      rr_ptr_d = rr_ptr_q + SEL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign d_rr_ptr = rr_ptr_q;
`else
  logic unused_mode;
  assign unused_mode = d_mode;
  assign d_rr_ptr    = '0;
`endif

  always_comb begin
    target = d_sel;
`ifdef DEMUX_RR_EN
    if (d_mode) begin
      target = rr_ptr_q;
    end
`endif
    // Slot is usable if empty or being emptied by its consumer this cycle.
    d_in_ready = !valid_q[target] || d_out_ready[target];
    accept     = d_in_valid && d_in_ready;

    data_d  = data_q;
    valid_d = valid_q;
    for (int k = 0; k < N_OUT; k++) begin
      if (valid_q[k] && d_out_ready[k]) begin
        valid_d[k] = 1'b0;
        data_d[k]  = '0;
      end
    end
    // Applied after the drain so a same-cycle drain+refill keeps valid high.
    if (accept) begin
      valid_d[target] = 1'b1;
      data_d[target]  = d_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign d_out       = data_q;
  assign d_out_valid = valid_q;

endmodule

// File: tb/tb_demux_stream.sv
module tb_demux_stream;

  localparam int WIDTH = 8;
  localparam int SEL_W = 2;
  localparam int N_OUT = 4;
`ifdef DEMUX_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [WIDTH-1:0]       d_in = '0;
  logic                   d_in_valid = 1'b0;
  logic                   d_in_ready;
  logic [SEL_W-1:0]       d_sel = '0;
  logic                   d_mode = 1'b0;
  logic [N_OUT*WIDTH-1:0] d_out;
  logic [N_OUT-1:0]       d_out_valid;
  logic [N_OUT-1:0]       d_out_ready = '0;
  logic [SEL_W-1:0]       d_rr_ptr;

  demux_stream #(.WIDTH(WIDTH), .SEL_W(SEL_W)) dut (
    .clk(clk), .rst(rst),
    .d_in(d_in), .d_in_valid(d_in_valid), .d_in_ready(d_in_ready),
    .d_sel(d_sel), .d_mode(d_mode),
    .d_out(d_out), .d_out_valid(d_out_valid), .d_out_ready(d_out_ready),
    .d_rr_ptr(d_rr_ptr)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
  endtask

  // Reference model: each channel is a one-deep mailbox (full flag + word),
  // the round-robin target is a plain integer modulo N_OUT.
  bit             m_full [N_OUT];
  logic [WIDTH-1:0] m_word [N_OUT];
  int             m_ptr;

  task automatic model_clear();
    for (int k = 0; k < N_OUT; k++) begin
      m_full[k] = 1'b0;
      m_word[k] = '0;
    end
    m_ptr = 0;
  endtask

  task automatic check_outputs();
    logic [N_OUT*WIDTH-1:0] exp_out;
    logic [N_OUT-1:0]       exp_vld;
    for (int k = 0; k < N_OUT; k++) begin
      exp_vld[k]               = m_full[k];
      exp_out[k*WIDTH +: WIDTH] = m_full[k] ? m_word[k] : '0;
    end
    check("out_valid", 32'(d_out_valid), 32'(exp_vld));
    check("out_data", d_out, exp_out);
    check("rr_ptr", 32'(d_rr_ptr), 32'(m_ptr));
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input logic r, input logic v, input logic [WIDTH-1:0] din,
                       input logic [SEL_W-1:0] sel, input logic mode,
                       input logic [N_OUT-1:0] rdy);
    int   t;
    logic exp_rdy;
    @(negedge clk);
    rst = r; d_in_valid = v; d_in = din; d_sel = sel; d_mode = mode; d_out_ready = rdy;
    t = (RR_EN && mode) ? m_ptr : int'(sel);
    exp_rdy = !m_full[t] || rdy[t];
    #1 check("in_ready", 32'(d_in_ready), 32'(exp_rdy));
    @(posedge clk);
    if (r) begin
      model_clear();
    end else begin
      for (int k = 0; k < N_OUT; k++)
        if (m_full[k] && rdy[k]) m_full[k] = 1'b0;
      if (v && exp_rdy) begin
        m_full[t] = 1'b1;
        m_word[t] = din;
        if (RR_EN && mode) m_ptr = (m_ptr + 1) % N_OUT;
      end
    end
    #1 check_outputs();
  endtask

  task automatic flush();
    cycle(1'b0, 1'b0, '0, '0, 1'b0, 4'hF);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_clear();

    // Reset with a word offered: nothing may be captured.
    cycle(1'b1, 1'b1, 8'hAA, 2'd0, 1'b0, 4'h0);
    check("rst_valid", 32'(d_out_valid), 32'h0);
    check("rst_data", d_out, 32'h0);
    check("rst_ptr", 32'(d_rr_ptr), 32'h0);
    #1 check("rst_ready", 32'(d_in_ready), 32'h1);

    // Directed routing, all consumers ready.
    for (int k = 0; k < N_OUT; k++) begin
      cycle(1'b0, 1'b1, 8'h10 + 8'(k), 2'(k), 1'b0, 4'hF);
      check("route_valid", 32'(d_out_valid), 32'(1 << k));
      check("route_data", 32'(d_out[k*WIDTH +: WIDTH]), 32'h10 + 32'(k));
    end
    flush();

    // Back-pressure on channel 2, then drain+refill in one cycle.
    cycle(1'b0, 1'b1, 8'h55, 2'd2, 1'b0, 4'b1011);
    cycle(1'b0, 1'b1, 8'h66, 2'd2, 1'b0, 4'b1011);
    check("bp_hold", 32'(d_out[2*WIDTH +: WIDTH]), 32'h55);
    cycle(1'b0, 1'b1, 8'h66, 2'd2, 1'b0, 4'b1111);
    check("bp_refill", 32'(d_out[2*WIDTH +: WIDTH]), 32'h66);
    check("bp_valid", 32'(d_out_valid[2]), 32'h1);
    flush();

    // Independent drain: channel 1 stalls while channel 0 keeps moving.
    cycle(1'b0, 1'b1, 8'hA0, 2'd0, 1'b0, 4'b0000);
    cycle(1'b0, 1'b1, 8'hA1, 2'd1, 1'b0, 4'b0000);
    cycle(1'b0, 1'b1, 8'hA2, 2'd0, 1'b0, 4'b1101);
    check("ind_ch0", 32'(d_out[0 +: WIDTH]), 32'hA2);
    check("ind_ch1", 32'(d_out[WIDTH +: WIDTH]), 32'hA1);
    flush();

`ifdef DEMUX_RR_EN
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b1, 8'(i + 1), 2'd3, 1'b1, 4'hF);
      check("rr_ch", 32'(d_out_valid), 32'(1 << (i % 4)));
      check("rr_ptr_seq", 32'(d_rr_ptr), 32'((i + 1) % 4));
    end
    cycle(1'b0, 1'b1, 8'h06, 2'd1, 1'b0, 4'b1101);
    cycle(1'b0, 1'b1, 8'h07, 2'd0, 1'b1, 4'b1101);
    check("rr_stall_ptr", 32'(d_rr_ptr), 32'h1);
    check("rr_stall_ch1", 32'(d_out[WIDTH +: WIDTH]), 32'h06);
`else
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, 8'hC0 + 8'(i), 2'd3, 1'b1, 4'hF);
      check("norr_ch3", 32'(d_out_valid), 32'h8);
      check("norr_ptr", 32'(d_rr_ptr), 32'h0);
    end
`endif
    flush();

    // Randomized traffic with occasional mid-stream resets.
    for (int n = 0; n < 400; n++) begin
      cycle($urandom_range(0, 99) == 0, 1'($urandom_range(0, 3) != 0),
            8'($urandom), 2'($urandom), 1'($urandom),
            {1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 9) < 7),
             1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 9) < 7)});
    end

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
